// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle RV32I-subset core: instruction field
// encodings, ALU operation and FSM state enums, and immediate decoders.
package cpu_pkg;

  // Major opcodes handled by the core
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // funct3 values
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;

  // funct7 values for register-register operations
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_t;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_TRAP
  } state_t;

  function automatic logic [31:0] imm_i(input logic [31:0] ir);
    return {{20{ir[31]}}, ir[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] ir);
    return {{20{ir[31]}}, ir[31:25], ir[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] ir);
    return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] ir);
    return {ir[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] ir);
    return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: add/sub/and/or/signed set-less-than, plus an equality
// flag on the raw operands used for branch resolution.
module cpu_alu
  import cpu_pkg::*;
(
  input  alu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y,
  output logic        eq
);

  // Select the arithmetic/logic result for the requested operation
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves it unassigned and infers a latch.
    y = a + b;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {31'b0, ($signed(a) < $signed(b))};
      default: y = a + b;
    endcase
  end

  assign eq = (a == b);

endmodule

// File: rtl/cpu_mc.sv
// Multi-cycle RV32I-subset core with req/ack instruction and data buses.
// FETCH -> EXEC -> (MEM ->) FETCH; one instruction in flight at a time.
// Optional trap unit enabled by defining CPU_MC_TRAP_EN: unknown opcodes and
// misaligned fetch/data addresses halt the core in TRAP until reset.
module cpu_mc
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          NREGS    = 32,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              n_reset,
  output logic              instr_req,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic              instr_ack,
  input  logic [31:0]       instr_rdata,
  output logic              data_req,
  output logic              data_we,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       data_wdata,
  input  logic              data_ack,
  input  logic [31:0]       data_rdata,
  output logic [31:0]       result,
  output logic              trap
);

  // With 16 registers the top bit of each register index is simply dropped.
  localparam int RIDX_W = (NREGS == 16) ? 4 : 5;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] result_q, result_d;
  logic        data_we_q, data_we_d;
  logic [31:0] data_wdata_q, data_wdata_d;
  logic        run_q, run_d;
  logic [31:0] regs_q [NREGS];

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [RIDX_W-1:0] rd_idx, rs1_idx, rs2_idx;
  logic [31:0]       rs1_val, rs2_val;

  alu_op_t     alu_op;
  logic [31:0] alu_a, alu_b, alu_y;
  logic        alu_eq;
  logic        wr_en, is_mem, is_store;
  logic [31:0] pc_plus4, next_pc, wr_val;
  logic        go_trap;
  logic        rf_we;
  logic [31:0] rf_wdata;

  assign opcode  = ir_q[6:0];
  assign funct3  = ir_q[14:12];
  assign funct7  = ir_q[31:25];
  assign rd_idx  = ir_q[7 +: RIDX_W];
  assign rs1_idx = ir_q[15 +: RIDX_W];
  assign rs2_idx = ir_q[20 +: RIDX_W];
  assign rs1_val = (rs1_idx == '0) ? 32'h0 : regs_q[rs1_idx];
  assign rs2_val = (rs2_idx == '0) ? 32'h0 : regs_q[rs2_idx];

  // Decode the latched instruction into ALU controls and write/memory flags
  always_comb begin
    alu_op   = ALU_ADD;
    alu_a    = rs1_val;
    alu_b    = imm_i(ir_q);
    wr_en    = 1'b0;
    is_mem   = 1'b0;
    is_store = 1'b0;
    case (opcode)
      OP_REG: begin
        alu_b = rs2_val;
        wr_en = 1'b1;
        case ({funct7, funct3})
          {F7_BASE, F3_ADD}: alu_op = ALU_ADD;
          {F7_SUB,  F3_ADD}: alu_op = ALU_SUB;
          {F7_BASE, F3_AND}: alu_op = ALU_AND;
          {F7_BASE, F3_OR}:  alu_op = ALU_OR;
          {F7_BASE, F3_SLT}: alu_op = ALU_SLT;
          default:           wr_en  = 1'b0;
        endcase
      end
      OP_IMM: begin
        wr_en = 1'b1;
        case (funct3)
          F3_ADD:  alu_op = ALU_ADD;
          F3_AND:  alu_op = ALU_AND;
          F3_OR:   alu_op = ALU_OR;
          F3_SLT:  alu_op = ALU_SLT;
          default: wr_en  = 1'b0;
        endcase
      end
      OP_LUI: begin
        alu_a = 32'h0;
        alu_b = imm_u(ir_q);
        wr_en = 1'b1;
      end
      OP_JAL: begin
        alu_a = pc_q;
        alu_b = imm_j(ir_q);
        wr_en = 1'b1;
      end
      OP_JALR:   wr_en = 1'b1;
      OP_BRANCH: alu_b = rs2_val;
      OP_LOAD:   is_mem = (funct3 == F3_LW);
      OP_STORE: begin
        alu_b    = imm_s(ir_q);
        is_mem   = (funct3 == F3_SW);
        is_store = (funct3 == F3_SW);
      end
      default: ;
    endcase
  end

  cpu_alu u_alu (
    .op (alu_op),
    .a  (alu_a),
    .b  (alu_b),
    .y  (alu_y),
    .eq (alu_eq)
  );

  // Resolve next PC and the register write-back value from the ALU outputs
  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    next_pc  = pc_plus4;
    wr_val   = alu_y;
    case (opcode)
      OP_JAL: begin
        next_pc = alu_y;
        wr_val  = pc_plus4;
      end
      OP_JALR: begin
        next_pc = {alu_y[31:1], 1'b0};
        wr_val  = pc_plus4;
      end
      OP_BRANCH: begin
        if ((funct3 == F3_BEQ && alu_eq) || (funct3 == F3_BNE && !alu_eq)) begin
          next_pc = pc_q + imm_b(ir_q);
        end
      end
      default: ;
    endcase
  end

`ifdef CPU_MC_TRAP_EN
  logic known_op;

  // Flag opcodes outside the supported subset
  always_comb begin
    known_op = opcode inside {OP_LUI, OP_JAL, OP_JALR, OP_BRANCH,
                              OP_LOAD, OP_STORE, OP_IMM, OP_REG};
  end

  assign go_trap = !known_op ||
                   (is_mem ? (alu_y[1:0] != 2'b00) : (next_pc[1:0] != 2'b00));
  assign trap    = (state_q == S_TRAP);
`else
  assign go_trap = 1'b0;
  assign trap    = 1'b0;
`endif

  // Next-state logic: sequence the bus handshakes and commit architectural state
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    result_d     = result_q;
    data_we_d    = data_we_q;
    data_wdata_d = data_wdata_q;
    rf_we        = 1'b0;
    rf_wdata     = wr_val;
    case (state_q)
      S_FETCH: begin
        if (instr_req && instr_ack) begin
          ir_d    = instr_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d = alu_y;
        if (go_trap) begin
          state_d = S_TRAP;
        end else if (is_mem) begin
          data_we_d = is_store;
          if (is_store) data_wdata_d = rs2_val;
          state_d = S_MEM;
        end else begin
          rf_we   = wr_en;
          pc_d    = next_pc;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        if (data_req && data_ack) begin
          rf_we    = !data_we_q;
          rf_wdata = data_rdata;
          pc_d     = pc_plus4;
          state_d  = S_FETCH;
        end
      end
      default: ;
    endcase
  end

  // Fetching starts one clock after reset is released.
  assign run_d = 1'b1;

  assign instr_req  = run_q && (state_q == S_FETCH);
  assign instr_addr = pc_q[ADDR_W-1:0];
  assign data_req   = (state_q == S_MEM);
  assign data_we    = data_we_q;
  assign data_addr  = result_q[ADDR_W-1:0];
  assign data_wdata = data_wdata_q;
  assign result     = result_q;

  // Control and datapath state registers
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      ir_q         <= 32'h0;
      result_q     <= 32'h0;
      data_we_q    <= 1'b0;
      data_wdata_q <= 32'h0;
      run_q        <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement or block order.
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      result_q     <= result_d;
      data_we_q    <= data_we_d;
      data_wdata_q <= data_wdata_d;
      run_q        <= run_d;
    end
  end

  // Register file: single write port, x0 writes discarded
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      // NOTE: the register file is reset because software relies on every
      // register reading zero after reset; a RAM macro could not provide this.
      for (int i = 0; i < NREGS; i++) regs_q[i] <= 32'h0;
    end else if (rf_we && rd_idx != '0) begin
      regs_q[rd_idx] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_cpu_mc.sv
// Directed self-checking bench for cpu_mc: the bench plays instruction and
// data memory, answering each request with hand-encoded instructions and
// checking bus behaviour and ALU results against hand-computed values.
module tb_cpu_mc;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_ack;
  logic [31:0] instr_rdata;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_ack;
  logic [31:0] data_rdata;
  logic [31:0] result;
  logic        trap;

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int fetch_cyc = 0;
  int lat_last  = 0;

  cpu_mc #(
    .RESET_PC (32'h0),
    .NREGS    (32),
    .ADDR_W   (32)
  ) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .instr_req   (instr_req),
    .instr_addr  (instr_addr),
    .instr_ack   (instr_ack),
    .instr_rdata (instr_rdata),
    .data_req    (data_req),
    .data_we     (data_we),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_ack    (data_ack),
    .data_rdata  (data_rdata),
    .result      (result),
    .trap        (trap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Instruction encoders
  function automatic logic [31:0] r_type(input logic [6:0] f7, input int rs2, input int rs1,
                                         input logic [2:0] f3, input int rd);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input int imm, input int rs1, input logic [2:0] f3,
                                         input int rd, input logic [6:0] op);
    return {12'(imm), 5'(rs1), f3, 5'(rd), op};
  endfunction

  function automatic logic [31:0] s_type(input int imm, input int rs2, input int rs1);
    logic [11:0] im;
    im = 12'(imm);
    return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] b_type(input int imm, input int rs2, input int rs1,
                                         input logic [2:0] f3);
    logic [12:0] im;
    im = 13'(imm);
    return {im[12], im[10:5], 5'(rs2), 5'(rs1), f3, im[4:1], im[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] u_lui(input int imm20, input int rd);
    return {20'(imm20), 5'(rd), 7'b0110111};
  endfunction

  function automatic logic [31:0] j_jal(input int imm, input int rd);
    logic [20:0] im;
    im = 21'(imm);
    return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'b1101111};
  endfunction

  // Wait (bounded) for a fetch, check its address, answer with zero wait,
  // and return at the falling edge after the EXEC cycle.
  task automatic do_instr(input logic [31:0] exp_pc, input logic [31:0] ins, input string tag);
    int n;
    n = 0;
    while (instr_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req"}, {31'b0, instr_req}, 32'd1);
    check({tag, "_addr"}, instr_addr, exp_pc);
    instr_rdata = ins;
    instr_ack   = 1'b1;
    @(posedge clk);
    #1 instr_ack = 1'b0;
    lat_last  = cyc - fetch_cyc;
    fetch_cyc = cyc;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Check the data request, hold it for wait_cyc clocks, then acknowledge.
  task automatic mem_access(input string tag, input logic exp_we, input logic [31:0] exp_addr,
                            input logic [31:0] exp_wdata, input int wait_cyc,
                            input logic [31:0] rdata);
    check({tag, "_dreq"}, {31'b0, data_req}, 32'd1);
    check({tag, "_we"}, {31'b0, data_we}, {31'b0, exp_we});
    check({tag, "_daddr"}, data_addr, exp_addr);
    if (exp_we) check({tag, "_wdata"}, data_wdata, exp_wdata);
    repeat (wait_cyc) @(negedge clk);
    if (wait_cyc > 0) check({tag, "_dreq_held"}, {31'b0, data_req}, 32'd1);
    data_rdata = rdata;
    data_ack   = 1'b1;
    @(posedge clk);
    #1 data_ack = 1'b0;
    @(negedge clk);
    check({tag, "_dreq_drop"}, {31'b0, data_req}, 32'd0);
  endtask

  initial begin
    n_reset     = 1'b0;
    instr_ack   = 1'b0;
    instr_rdata = 32'h0;
    data_ack    = 1'b0;
    data_rdata  = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_instr_req", {31'b0, instr_req}, 32'd0);
    check("rst_data_req", {31'b0, data_req}, 32'd0);
    check("rst_data_we", {31'b0, data_we}, 32'd0);
    check("rst_data_wdata", data_wdata, 32'h0);
    check("rst_result", result, 32'h0);
    check("rst_trap", {31'b0, trap}, 32'd0);

    // Release reset with stray acks while no request is outstanding
    n_reset     = 1'b1;
    instr_rdata = i_type(12'h123, 0, 3'b000, 1, 7'b0010011);
    instr_ack   = 1'b1;
    data_ack    = 1'b1;
    data_rdata  = 32'hDEAD_BEEF;
    #1 check("req_low_at_release", {31'b0, instr_req}, 32'd0);
    @(posedge clk);
    #1;
    instr_ack = 1'b0;
    data_ack  = 1'b0;
    check("req_first_clk", {31'b0, instr_req}, 32'd1);
    @(negedge clk);
    fetch_cyc = cyc;

    // addi x1,x0,0xF0
    do_instr(32'h000, i_type(32'hF0, 0, 3'b000, 1, 7'b0010011), "addi");
    check("addi_result", result, 32'h0000_00F0);

    // lw x1,0(x0) with slow data response
    do_instr(32'h004, i_type(0, 0, 3'b010, 1, 7'b0000011), "lw0");
    check("lw0_result", result, 32'h0);
    mem_access("lw0", 1'b0, 32'h0, 32'h0, 3, 32'h0000_00FF);

    // add x1,x1,x1 -> 0x1FE
    do_instr(32'h008, r_type(7'h00, 1, 1, 3'b000, 1), "add");
    check("add_result", result, 32'h0000_01FE);

    // beq x0,x0,+12 from 0x0C
    do_instr(32'h00C, b_type(12, 0, 0, 3'b000), "beq");
    check("beq_result", result, 32'h0);
    check("alu_latency", lat_last, 32'd2);

    // sw x1,0(x0) at branch target 0x18, zero-wait
    do_instr(32'h018, s_type(0, 1, 0), "sw");
    mem_access("sw", 1'b1, 32'h0, 32'h0000_01FE, 0, 32'h0);

    // addi x1,x0,0 ; bne x1,x0,+16 not taken
    do_instr(32'h01C, i_type(0, 0, 3'b000, 1, 7'b0010011), "clr");
    check("sw_latency", lat_last, 32'd3);
    do_instr(32'h020, b_type(16, 0, 1, 3'b001), "bne_nt");
    check("bne_nt_result", result, 32'h0);

    // jal x0,0xAC ; jal x1,0x200 ; jalr x1,x1,0x100
    do_instr(32'h024, j_jal(32'hAC, 0), "jal0");
    do_instr(32'h0D0, j_jal(32'h200, 1), "jal1");
    do_instr(32'h2D0, i_type(32'h100, 1, 3'b000, 1, 7'b1100111), "jalr");

    // add x2,x1,x0 -> link value 0x2D4
    do_instr(32'h1D4, r_type(7'h00, 0, 1, 3'b000, 2), "link");
    check("link_result", result, 32'h0000_02D4);

    // lui x3,0x80000
    do_instr(32'h1D8, u_lui(32'h80000, 3), "lui");
    check("lui_result", result, 32'h8000_0000);

    // slt x4,x3,x2 (signed: negative < positive)
    do_instr(32'h1DC, r_type(7'h00, 2, 3, 3'b010, 4), "slt");
    check("slt_result", result, 32'h1);

    // slti x4,x2,-1
    do_instr(32'h1E0, i_type(-1, 2, 3'b010, 4, 7'b0010011), "slti");
    check("slti_result", result, 32'h0);

    // sub x5,x0,x2
    do_instr(32'h1E4, r_type(7'h20, 2, 0, 3'b000, 5), "sub");
    check("sub_result", result, 32'hFFFF_FD2C);

    // andi x6,x5,0xFF
    do_instr(32'h1E8, i_type(32'hFF, 5, 3'b111, 6, 7'b0010011), "andi");
    check("andi_result", result, 32'h0000_002C);

    // ori x7,x6,-256
    do_instr(32'h1EC, i_type(-256, 6, 3'b110, 7, 7'b0010011), "ori");
    check("ori_result", result, 32'hFFFF_FF2C);

    // and x8,x7,x2
    do_instr(32'h1F0, r_type(7'h00, 2, 7, 3'b111, 8), "and");
    check("and_result", result, 32'h0000_0204);

    // or x9,x3,x6
    do_instr(32'h1F4, r_type(7'h00, 6, 3, 3'b110, 9), "or");
    check("or_result", result, 32'h8000_002C);

    // addi x0,x0,5 then add x10,x0,x0: x0 must still read zero
    do_instr(32'h1F8, i_type(5, 0, 3'b000, 0, 7'b0010011), "x0_wr");
    check("x0_wr_result", result, 32'h5);
    do_instr(32'h1FC, r_type(7'h00, 0, 0, 3'b000, 10), "x0_rd");
    check("x0_rd_result", result, 32'h0);

    // Unknown opcode 0x7F executes as a nop
    do_instr(32'h200, 32'h0000_007F, "unk");

    // add x11,x3,x3 wraps to zero
    do_instr(32'h204, r_type(7'h00, 3, 3, 3'b000, 11), "wrap");
    check("wrap_result", result, 32'h0);

    // bne x3,x0,-8 taken backwards
    do_instr(32'h208, b_type(-8, 0, 3, 3'b001), "bne_t");
    check("bne_t_result", result, 32'h8000_0000);

    // lw x12,-44(x9) with negative offset
    do_instr(32'h200, i_type(-44, 9, 3'b010, 12, 7'b0000011), "lw1");
    check("lw1_result", result, 32'h8000_0000);
    mem_access("lw1", 1'b0, 32'h8000_0000, 32'h0, 1, 32'hCAFE_F00D);

    // add x13,x12,x0 exposes the loaded value
    do_instr(32'h204, r_type(7'h00, 0, 12, 3'b000, 13), "use_ld");
    check("use_ld_result", result, 32'hCAFE_F00D);
    check("trap_idle", {31'b0, trap}, 32'd0);

    // Reset in the middle of a load
    do_instr(32'h208, i_type(0, 0, 3'b010, 14, 7'b0000011), "lw2");
    check("lw2_dreq", {31'b0, data_req}, 32'd1);
    n_reset = 1'b0;
    #1;
    check("midrst_dreq", {31'b0, data_req}, 32'd0);
    check("midrst_ireq", {31'b0, instr_req}, 32'd0);
    check("midrst_result", result, 32'h0);
    data_rdata = 32'h1234_5678;
    data_ack   = 1'b1;
    @(negedge clk);
    n_reset = 1'b1;
    @(posedge clk);
    #1 data_ack = 1'b0;
    check("postrst_dreq", {31'b0, data_req}, 32'd0);
    @(negedge clk);

    // Restart from RESET_PC with a cleared register file
    do_instr(32'h000, i_type(32'hF0, 0, 3'b000, 1, 7'b0010011), "re_addi");
    check("re_addi_result", result, 32'h0000_00F0);
    do_instr(32'h004, r_type(7'h00, 0, 2, 3'b000, 15), "re_x2");
    check("re_x2_result", result, 32'h0);
    check("re_latency", lat_last, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
